acond_botones: RTL and testbench

Input conditioner for the food-menu pushbuttons. It synchronises and debounces the four raw buttons: advance, back, select and clear. It then turns each debounced press into a single-cycle command pulse on AD, AT, SEL and CLC, which drive the menu state machine directly. At most one command pulse is issued per cycle, and advance/back auto-repeat while held.

---
 rtl/acond_botones.sv | 168 ++++++++++++++++
 tb/tb_acond_botones.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/acond_botones.sv
// acond_botones: pushbutton conditioner for the menu FSM.
// Each raw button is synchronised, debounced and edge-detected; advance/back
// auto-repeat while held. A fixed-priority arbiter (CLC > SEL > AT > AD)
// registers at most one single-cycle command pulse per clock.
module acond_botones #(
   parameter int unsigned DEB_CYCLES = 500000,
   parameter int unsigned REP_DELAY  = 25000000,
   parameter int unsigned REP_PERIOD = 10000000
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       btn_ad,
   input  logic       btn_at,
   input  logic       btn_sel,
   input  logic       btn_clc,
   output logic       AD,
   output logic       AT,
   output logic       SEL,
   output logic       CLC,
   output logic [3:0] held
);

   localparam int unsigned DW = $clog2(DEB_CYCLES + 1);
   // REP_DELAY > REP_PERIOD, so one width covers both repeat intervals.
   localparam int unsigned RW = $clog2(REP_DELAY + 1);

   localparam logic [DW-1:0] DebLast   = DW'(DEB_CYCLES - 1);
   localparam logic [RW-1:0] RepDelay  = RW'(REP_DELAY);
   localparam logic [RW-1:0] RepPeriod = RW'(REP_PERIOD);

   typedef enum logic [1:0] {StIdle, StDelay, StPeriod} rep_state_e;

   // Bit order everywhere: {clc, sel, at, ad}.
   logic [3:0] raw;
   logic [3:0] sync1_q, sync2_q;
   logic [3:0] deb;
   logic [3:0] deb_prev_q;
   logic [3:0] press;
   logic [1:0] rep;
   logic [3:0] req;
   logic [3:0] grant_d, out_q;

   assign raw = {btn_clc, btn_sel, btn_at, btn_ad};

   // Two-flop synchroniser for the asynchronous button inputs.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         sync1_q <= '0;
         sync2_q <= '0;
      end else begin
         sync1_q <= raw;
         sync2_q <= sync1_q;
      end
   end

   for (genvar i = 0; i < 4; i++) begin : g_deb
      logic          deb_q;
      logic [DW-1:0] cnt_q;

      // Accept a new level only after it persists for DEB_CYCLES cycles.
      always_ff @(posedge clk or negedge reset) begin
         if (!reset) begin
            deb_q <= 1'b0;
            cnt_q <= '0;
         end else if (sync2_q[i] == deb_q) begin
            cnt_q <= '0;
         end else if (cnt_q == DebLast) begin
            deb_q <= sync2_q[i];
            cnt_q <= '0;
         end else begin
            cnt_q <= cnt_q + DW'(1);
         end
      end

      assign deb[i] = deb_q;
   end

   // Previous debounced level, for rising-edge (press) detection.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         deb_prev_q <= '0;
      end else begin
         deb_prev_q <= deb;
      end
   end

   assign press = deb & ~deb_prev_q;

   for (genvar i = 0; i < 2; i++) begin : g_rep
      rep_state_e    state_q;
      logic [RW-1:0] cnt_q;

      // Repeat timer; runs on schedule regardless of whether its requests win.
      always_ff @(posedge clk or negedge reset) begin
         if (!reset) begin
            state_q <= StIdle;
            cnt_q   <= '0;
         end else if (!deb[i]) begin
            state_q <= StIdle;
            cnt_q   <= '0;
         end else begin
            case (state_q)
               StIdle: begin
                  if (press[i]) begin
                     state_q <= StDelay;
                     cnt_q   <= RW'(1);
                  end
               end
               StDelay: begin
                  if (cnt_q == RepDelay) begin
                     state_q <= StPeriod;
                     cnt_q   <= RW'(1);
                  end else begin
                     cnt_q <= cnt_q + RW'(1);
                  end
               end
               StPeriod: begin
                  if (cnt_q == RepPeriod) begin
                     cnt_q <= RW'(1);
                  end else begin
                     cnt_q <= cnt_q + RW'(1);
                  end
               end
               default: begin
                  state_q <= StIdle;
                  cnt_q   <= '0;
               end
            endcase
         end
      end

      assign rep[i] = deb[i] &&
                      (((state_q == StDelay) && (cnt_q == RepDelay)) ||
                       ((state_q == StPeriod) && (cnt_q == RepPeriod)));
   end

   assign req = {press[3], press[2], press[1] | rep[1], press[0] | rep[0]};

   // Fixed-priority pick; losing requests are dropped, not queued.
   always_comb begin
      grant_d = 4'b0000;
      if (req[3]) begin
         grant_d = 4'b1000;
      end else if (req[2]) begin
         grant_d = 4'b0100;
      end else if (req[1]) begin
         grant_d = 4'b0010;
      end else if (req[0]) begin
         grant_d = 4'b0001;
      end
   end

   // Registered command outputs.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         out_q <= '0;
      end else begin
         out_q <= grant_d;
      end
   end

   assign AD   = out_q[0];
   assign AT   = out_q[1];
   assign SEL  = out_q[2];
   assign CLC  = out_q[3];
   assign held = deb;

endmodule

// File: tb/tb_acond_botones.sv
// Bench for acond_botones: directed test-plan scenarios plus random button
// activity, checked every cycle against a history-based reference model.
module tb_acond_botones;

   localparam int DEB = 4;
   localparam int RD  = 20;
   localparam int RP  = 6;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic [3:0] btns = 4'b0000;  // {clc, sel, at, ad}
   logic       AD, AT, SEL, CLC;
   logic [3:0] held;

   int tests = 0;
   int fails = 0;
   int cnt_ad = 0, cnt_at = 0, cnt_sel = 0, cnt_clc = 0;
   int cyc = 0;

   logic [7:0] exp_q[$];

   acond_botones #(
      .DEB_CYCLES(DEB),
      .REP_DELAY (RD),
      .REP_PERIOD(RP)
   ) dut (
      .clk    (clk),
      .reset  (rst),
      .btn_ad (btns[0]),
      .btn_at (btns[1]),
      .btn_sel(btns[2]),
      .btn_clc(btns[3]),
      .AD     (AD),
      .AT     (AT),
      .SEL    (SEL),
      .CLC    (CLC),
      .held   (held)
   );

   always #5 clk = ~clk;

   // Reference model: deb flips once DEB consecutive synchronised samples
   // (raw delayed by two edges) disagree with it; a press pulses one edge
   // after deb rises; repeats fall at P+RD+k*RP while deb stays high.
   bit hist[4][$];
   bit m_deb[4];
   bit m_prev[4];
   int p_edge[2];
   int n_edge = 0;

   initial begin
      for (int i = 0; i < 4; i++) begin
         for (int k = 0; k <= DEB; k++) hist[i].push_back(1'b0);
         m_deb[i]  = 1'b0;
         m_prev[i] = 1'b0;
      end
      p_edge[0] = -1;
      p_edge[1] = -1;
   end

   always @(posedge clk) begin
      bit       nd[4];
      bit [3:0] cand;
      bit [3:0] grant;
      bit [3:0] hv;
      int       d;
      if (!rst) begin
         for (int i = 0; i < 4; i++) begin
            for (int k = 0; k <= DEB; k++) hist[i][k] = 1'b0;
            m_deb[i]  = 1'b0;
            m_prev[i] = 1'b0;
         end
         p_edge[0] = -1;
         p_edge[1] = -1;
         exp_q.push_back(8'h00);
      end else begin
         for (int i = 0; i < 4; i++) begin
            bit all_diff;
            all_diff = 1'b1;
            for (int k = 1; k <= DEB; k++)
               if (hist[i][k] == m_deb[i]) all_diff = 1'b0;
            nd[i]   = all_diff ? ~m_deb[i] : m_deb[i];
            cand[i] = m_deb[i] && !m_prev[i];
         end
         for (int i = 0; i < 2; i++) begin
            if (!m_deb[i]) p_edge[i] = -1;
            if (cand[i]) begin
               p_edge[i] = n_edge;
            end else if (p_edge[i] >= 0) begin
               d = n_edge - p_edge[i];
               if (d == RD || (d > RD && (d - RD) % RP == 0)) cand[i] = 1'b1;
            end
         end
         grant = 4'b0000;
         if (cand[3]) grant = 4'b1000;
         else if (cand[2]) grant = 4'b0100;
         else if (cand[1]) grant = 4'b0010;
         else if (cand[0]) grant = 4'b0001;
         for (int i = 0; i < 4; i++) hv[i] = nd[i];
         exp_q.push_back({grant, hv});
         for (int i = 0; i < 4; i++) begin
            m_prev[i] = m_deb[i];
            m_deb[i]  = nd[i];
            hist[i].push_front(btns[i]);
            void'(hist[i].pop_back());
         end
      end
      n_edge++;
   end

   // Monitor: compare DUT outputs against the oldest model prediction.
   always @(negedge clk) begin
      logic [7:0] e, a;
      cyc++;
      if (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         a = {CLC, SEL, AT, AD, held};
         tests++;
         if (a !== e) begin
            fails++;
            $display("FAIL outputs cycle %0d: got {CLC,SEL,AT,AD,held}=%b expected %b",
                     cyc, a, e);
         end
         tests++;
         if ($countones({CLC, SEL, AT, AD}) > 1) begin
            fails++;
            $display("FAIL onehot cycle %0d: got %b expected at most one pulse",
                     cyc, {CLC, SEL, AT, AD});
         end
         if (AD === 1'b1) cnt_ad++;
         if (AT === 1'b1) cnt_at++;
         if (SEL === 1'b1) cnt_sel++;
         if (CLC === 1'b1) cnt_clc++;
      end
   end

   task automatic hold(input logic [3:0] v, input int n);
      btns = v;
      repeat (n) @(negedge clk);
   endtask

   task automatic check_cnt(input string name, input int act, input int exp);
      tests++;
      if (act != exp) begin
         fails++;
         $display("FAIL %s: got %0d pulses expected %0d", name, act, exp);
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $display("[TB] %0d tests run, %0d failed", tests, fails + 1);
      $fatal(1);
   end

   initial begin
      int b0;
      repeat (3) @(negedge clk);
      #2 rst = 1'b1;
      hold(4'b0000, 5);

      // Clean press.
      b0 = cnt_ad;
      hold(4'b0001, 10);
      hold(4'b0000, 20);
      check_cnt("clean_press_AD", cnt_ad - b0, 1);

      // Bounce: never stable for DEB cycles.
      b0 = cnt_sel;
      hold(4'b0100, 3);
      hold(4'b0000, 2);
      hold(4'b0100, 3);
      hold(4'b0000, 15);
      check_cnt("bounce_SEL", cnt_sel - b0, 0);

      // Auto-repeat on back.
      b0 = cnt_at;
      hold(4'b0010, 60);
      hold(4'b0000, 20);
      check_cnt("repeat_AT", cnt_at - b0, 8);

      // Simultaneous select + advance.
      b0 = cnt_sel;
      hold(4'b0101, 40);
      hold(4'b0000, 20);
      check_cnt("simul_SEL", cnt_sel - b0, 1);

      // Clear held long: no repeat.
      b0 = cnt_clc;
      hold(4'b1000, 100);
      hold(4'b0000, 20);
      check_cnt("clc_hold", cnt_clc - b0, 1);

      // Reset mid-debounce with the button held throughout.
      b0 = cnt_ad;
      hold(4'b0001, 3);
      #2 rst = 1'b0;
      hold(4'b0001, 5);
      #2 rst = 1'b1;
      hold(4'b0001, 20);
      hold(4'b0000, 20);
      check_cnt("reset_mid_AD", cnt_ad - b0, 1);

      // Random activity with occasional resets.
      for (int c = 0; c < 3000; c++) begin
         logic [3:0] v;
         v = btns;
         for (int i = 0; i < 4; i++)
            if ($urandom_range(0, 11) == 0) v[i] = ~v[i];
         if ($urandom_range(0, 499) == 0) begin
            #2 rst = 1'b0;
            hold(v, $urandom_range(1, 3));
            #2 rst = 1'b1;
         end else begin
            hold(v, 1);
         end
      end
      hold(4'b0000, 40);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
